// File: rtl/pe_seq_ctrl.sv
// Accumulate-path sequencer for one PE: runs a dot-product window over a product stream.
// Define PE_SAT_EN to make the accumulator add saturate instead of wrapping.
module pe_seq_ctrl #(
  parameter int W    = 24,
  parameter int KMAX = 256,
  parameter int CW   = $clog2(KMAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       cfg_len,
  input  logic signed [W-1:0] bias,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] prod,
  output logic                mux_sel,
  output logic signed [W-1:0] acc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       len_q, cnt, len_eff;
  logic signed [W-1:0] bias_q, addend, sum_raw, sum_next;
  logic                first, last_beat;

  assign len_eff   = (cfg_len > CW'(KMAX)) ? CW'(KMAX) : cfg_len;
  assign last_beat = (cnt == len_q - CW'(1));
  assign addend    = first ? bias_q : acc;
  assign sum_raw   = addend + prod;

`ifdef PE_SAT_EN
  // Overflow only when both operands share a sign and the sum's sign differs.
  logic ovf;
  assign ovf      = (addend[W-1] == prod[W-1]) && (sum_raw[W-1] != addend[W-1]);
  assign sum_next = !ovf ? sum_raw :
                    addend[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign sum_next = sum_raw;
`endif

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? acc : '0;
  assign mux_sel   = ~first;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = (len_eff == '0) ? OUT : ACC;
      ACC:  if (in_valid && last_beat) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // first is re-armed on leaving OUT so mux_sel reads 0 whenever the sequencer is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      bias_q <= '0;
      cnt    <= '0;
      first  <= 1'b1;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q  <= len_eff;
          bias_q <= bias;
          cnt    <= '0;
          first  <= 1'b1;
          if (len_eff == '0) acc <= bias;
        end
        ACC: if (in_valid) begin
          acc   <= sum_next;
          first <= 1'b0;
          cnt   <= cnt + CW'(1);
        end
        OUT: if (out_ready) first <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
